mux_2x1_rr_arb: RTL and testbench

MUX_2X1_RR_ARB -- requirements
Module: mux_2x1_rr_arb

---
 rtl/mux_2x1_rr_arb.sv | 72 +++++++
 tb/tb_mux_2x1_rr_arb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mux_2x1_rr_arb.sv
// Purpose: two-channel valid/ready mux with round-robin tie-break into one registered output slot.
// Latency: one cycle from input transfer to f_valid with the word on f.
// Backpressure: input readies drop whenever the output slot is full and f_ready is low.
module mux_2x1_rr_arb #(
    parameter int n = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [n-1:0] w0,
    input  logic         w0_valid,
    output logic         w0_ready,
    input  logic [n-1:0] w1,
    input  logic         w1_valid,
    output logic         w1_ready,
    output logic [n-1:0] f,
    output logic         f_valid,
    input  logic         f_ready,
    output logic         s
);

    // prio: 0 lets w0 win a tie, 1 lets w1 win a tie
    logic prio;

    // Output slot can take a new word when empty or being drained this cycle
    logic load_en;

    // Arbitration result: any request present, and which channel wins
    logic gnt_any;
    logic gnt_idx;

    // Grant: a lone requester always wins; on a tie prio decides
    always_comb begin
        load_en = !f_valid || f_ready;
        gnt_any = w0_valid || w1_valid;
        gnt_idx = 1'b0;
        if (w0_valid && w1_valid) begin
            gnt_idx = prio;
        end else if (w1_valid) begin
            gnt_idx = 1'b1;
        end
    end

    // Readies are one-hot by construction; gated by reset_n so nothing is accepted in reset
    always_comb begin
        w0_ready = 1'b0;
        w1_ready = 1'b0;
        if (reset_n && load_en && gnt_any) begin
            w0_ready = !gnt_idx;
            w1_ready = gnt_idx;
        end
    end

    // Output slot and priority: load on grant, empty on idle drain, hold on stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f       <= '0;
            s       <= 1'b0;
            f_valid <= 1'b0;
            prio    <= 1'b0;
        end else if (load_en) begin
            if (gnt_any) begin
                f       <= gnt_idx ? w1 : w0;
                s       <= gnt_idx;
                f_valid <= 1'b1;
                prio    <= !gnt_idx;
            end else begin
                f_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_2x1_rr_arb.sv
// Purpose: self-checking bench for mux_2x1_rr_arb (directed steps plus random traffic).
// Latency: checks outputs one cycle after each input transfer.
// Backpressure: randomly toggles f_ready and tracks words through a scoreboard queue.
module tb_mux_2x1_rr_arb;

    logic       clk;
    logic       reset_n;
    logic [2:0] w0;
    logic       w0_valid;
    logic       w0_ready;
    logic [2:0] w1;
    logic       w1_valid;
    logic       w1_ready;
    logic [2:0] f;
    logic       f_valid;
    logic       f_ready;
    logic       s;

    int ncmp;
    int nfail;

    // Reference state: the word sitting in the output slot and who wins the next tie
    logic [2:0] m_f;
    logic       m_s;
    logic       m_fv;
    logic       m_prio;

    // Words accepted but not yet delivered, as {source, data}, in grant order
    logic [3:0] sb[$];

    mux_2x1_rr_arb #(.n(3)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .w0       (w0),
        .w0_valid (w0_valid),
        .w0_ready (w0_ready),
        .w1       (w1),
        .w1_valid (w1_valid),
        .w1_ready (w1_ready),
        .f        (f),
        .f_valid  (f_valid),
        .f_ready  (f_ready),
        .s        (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1; asserts reset asynchronously and checks the forced values
    task automatic do_reset();
        reset_n  = 1'b0;
        w0_valid = 1'b1;
        w1_valid = 1'b1;
        w0       = 3'b111;
        w1       = 3'b110;
        f_ready  = 1'b1;
        #1;
        chk("rst_f",        32'(f),        32'd0);
        chk("rst_s",        32'(s),        32'd0);
        chk("rst_f_valid",  32'(f_valid),  32'd0);
        chk("rst_w0_ready", 32'(w0_ready), 32'd0);
        chk("rst_w1_ready", 32'(w1_ready), 32'd0);
        chk("rst_prio",     32'(dut.prio), 32'd0);
        m_f = 3'd0; m_s = 1'b0; m_fv = 1'b0; m_prio = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        chk("rst_hold_f_valid", 32'(f_valid), 32'd0);
        reset_n = 1'b1;
    endtask

    // One clock cycle: entered at posedge+1, leaves at the next posedge+1
    task automatic cycle(input logic v0, input logic [2:0] d0,
                         input logic v1, input logic [2:0] d1, input logic fr);
        logic       room;
        logic       win;
        logic       any;
        logic [3:0] exp_word;
        w0 = d0; w0_valid = v0;
        w1 = d1; w1_valid = v1;
        f_ready = fr;
        #2;
        room = !m_fv || fr;
        any  = v0 || v1;
        win  = (v0 && v1) ? m_prio : v1;
        chk("w0_ready", 32'(w0_ready), 32'(room && any && !win));
        chk("w1_ready", 32'(w1_ready), 32'(room && any && win));
        if (m_fv && fr) begin
            if (sb.size() == 0) begin
                chk("sb_spurious_output", 32'd1, 32'd0);
            end else begin
                exp_word = sb.pop_front();
                chk("sb_word", 32'({s, f}), 32'(exp_word));
            end
        end
        if (room && any) sb.push_back({win, win ? d1 : d0});
        @(posedge clk); #1;
        if (room) begin
            if (any) begin
                m_f = win ? d1 : d0;
                m_s = win;
                m_fv = 1'b1;
                m_prio = !win;
            end else begin
                m_fv = 1'b0;
            end
        end
        chk("f",       32'(f),       32'(m_f));
        chk("s",       32'(s),       32'(m_s));
        chk("f_valid", 32'(f_valid), 32'(m_fv));
    endtask

    initial begin
        logic [2:0] tie_f[4];
        logic       tie_s[4];
        ncmp = 0; nfail = 0;
        reset_n = 1'b0;
        w0 = '0; w1 = '0; w0_valid = 1'b0; w1_valid = 1'b0; f_ready = 1'b0;
        m_f = '0; m_s = 1'b0; m_fv = 1'b0; m_prio = 1'b0;
        @(posedge clk); #1;

        // Reset with both channels requesting, then first edge grants w0
        do_reset();
        cycle(1'b1, 3'd6, 1'b1, 3'd1, 1'b1);
        chk("post_rst_grant_s", 32'(s), 32'd0);
        chk("post_rst_grant_f", 32'(f), 32'd6);

        // Tie round-robin: 101 / 010 alternate
        do_reset();
        tie_f[0] = 3'b101; tie_f[1] = 3'b010; tie_f[2] = 3'b101; tie_f[3] = 3'b010;
        tie_s[0] = 1'b0;   tie_s[1] = 1'b1;   tie_s[2] = 1'b0;   tie_s[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 3'b101, 1'b1, 3'b010, 1'b1);
            chk("tie_f", 32'(f), 32'(tie_f[i]));
            chk("tie_s", 32'(s), 32'(tie_s[i]));
        end

        // Single channel: only w1 stepping 1,2,3
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b0, 3'd7, 1'b1, 3'(i), 1'b1);
            chk("single_f", 32'(f), 32'(i));
            chk("single_s", 32'(s), 32'd1);
        end

        // Back-pressure: hold 101 for three stalled cycles
        do_reset();
        cycle(1'b1, 3'b101, 1'b1, 3'b010, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 3'b101, 1'b1, 3'b010, 1'b0);
            chk("bp_f",        32'(f),        32'b101);
            chk("bp_s",        32'(s),        32'd0);
            chk("bp_f_valid",  32'(f_valid),  32'd1);
            chk("bp_prio",     32'(dut.prio), 32'd1);
        end
        cycle(1'b1, 3'b101, 1'b1, 3'b010, 1'b1);
        chk("bp_next_f", 32'(f), 32'b010);
        chk("bp_next_s", 32'(s), 32'd1);

        // Drain: no requests, slot empties, f and s hold
        cycle(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
        chk("drain_f_valid", 32'(f_valid), 32'd0);
        chk("drain_f",       32'(f),       32'b010);
        chk("drain_s",       32'(s),       32'd1);

        // Mid-stream reset discards the held word without a clock edge
        cycle(1'b0, 3'd3, 1'b1, 3'd4, 1'b0);
        cycle(1'b1, 3'd3, 1'b1, 3'd5, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_f_valid", 32'(f_valid),  32'd0);
        chk("mid_rst_prio",    32'(dut.prio), 32'd0);
        chk("mid_rst_w0_rdy",  32'(w0_ready), 32'd0);
        chk("mid_rst_w1_rdy",  32'(w1_ready), 32'd0);
        m_f = 3'd0; m_s = 1'b0; m_fv = 1'b0; m_prio = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        cycle(1'b1, 3'd2, 1'b1, 3'd7, 1'b1);
        chk("mid_rst_tie_w0", 32'(s), 32'd0);

        // Random traffic against the reference model and scoreboard
        for (int i = 0; i < 500; i++) begin
            cycle(1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
                  1'($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
